// File: rtl/ak_serial_add16.sv
// ak_serial_add16: nibble-serial adder/subtractor controller.
// Streams two W-bit operands through an external 4-bit ripple-carry adder
// one nibble per cycle, LSB nibble first. It collects the sum nibbles and the
// final carry, and it returns result, carry-out and signed overflow on a
// valid/ready handshake.
module ak_serial_add16 #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  input  logic         sub,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_c0,
  input  logic [3:0]   add_sum,
  input  logic         add_c4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          carry_r;
  logic [IW-1:0] idx_r;
  logic [W-1:0]  result_r;
  logic          cout_r;
  logic          overflow_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          last_s;
  logic [IW+1:0] base_s;

  // Bit offset of the nibble currently in the adder, and last-slice flag.
  assign base_s = {idx_r, 2'b00};
  assign last_s = (idx_r == LAST_IDX);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign overflow  = overflow_r;

  // Next-state logic: accept in IDLE, step through slices in RUN, hold result in DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Adder drive: present the current slice during RUN, otherwise park the inputs at zero.
  always_comb begin
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_c0 = 1'b0;
    if (state_r == RUN) begin
      add_a  = a_r[base_s +: 4];
      add_b  = b_r[base_s +: 4];
      add_c0 = carry_r;
    end else begin
      add_a  = 4'h0;
      add_b  = 4'h0;
      add_c0 = 1'b0;
    end
  end

  // State, operand capture, per-slice result collection and registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      result_r    <= '0;
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= op_a;
            // Subtract is A + ~B + 1: invert B once at capture and force carry-in.
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub ? 1'b1 : cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          result_r[base_s +: 4] <= add_sum;
          carry_r               <= add_c4;
          if (last_s) begin
            cout_r     <= add_c4;
            overflow_r <= (a_r[W-1] == b_r[W-1]) && (add_sum[3] != a_r[W-1]);
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          // Result, cout and overflow hold until the downstream handshake.
        end
        default: begin
          // Unreachable encodings recover through state_s.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ak_serial_add16.sv
// Testbench for ak_serial_add16: models the external 4-bit adder, drives
// directed vectors and checks results via a queue-based scoreboard.
module tb_ak_serial_add16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        sub;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_c0;
  logic [3:0]  add_sum;
  logic        add_c4;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        overflow;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ak_serial_add16 #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_sum(add_sum), .add_c4(add_c4),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  // Behavioural 4-bit ripple-carry adder stage sitting next to the DUT.
  assign {add_c4, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the oldest expectation on every result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {16'h0, result}, {16'h0, e.res});
        check("cout", {31'h0, cout}, {31'h0, e.c});
        check("overflow", {31'h0, overflow}, {31'h0, e.o});
      end
    end
  end

  // One operation: c0_seq[k] is the hand-computed add_c0 at slice k;
  // hold > 0 keeps out_ready low in DONE and offers ignored operands.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input logic [15:0] er, input logic ec,
                        input logic eo, input logic [3:0] c0_seq, input int hold);
    int n;
    logic [15:0] bx;
    exp_t e;
    bx = s ? ~b : b;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'h0, in_ready}, 32'd1);
    in_valid = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    e.res = er; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("add_a", {28'h0, add_a}, {28'h0, a[4*k +: 4]});
      check("add_b", {28'h0, add_b}, {28'h0, bx[4*k +: 4]});
      check("add_c0", {31'h0, add_c0}, {31'h0, c0_seq[k]});
      check("run_out_valid", {31'h0, out_valid}, 32'd0);
      check("run_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(negedge clk);
    check("latency_out_valid", {31'h0, out_valid}, 32'd1);
    if (hold > 0) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = 16'hDEAD; op_b = 16'hBEEF; cin = 1'b1; sub = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("bp_out_valid", {31'h0, out_valid}, 32'd1);
        check("bp_in_ready", {31'h0, in_ready}, 32'd0);
        check("bp_result", {16'h0, result}, {16'h0, er});
        check("bp_cout", {31'h0, cout}, {31'h0, ec});
        check("bp_overflow", {31'h0, overflow}, {31'h0, eo});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    check("idle_in_ready", {31'h0, in_ready}, 32'd1);
    check("idle_out_valid", {31'h0, out_valid}, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_a = 16'h0; op_b = 16'h0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_result", {16'h0, result}, 32'd0);
    check("rst_cout", {31'h0, cout}, 32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
    check("rst_add_a", {28'h0, add_a}, 32'd0);
    check("rst_add_b", {28'h0, add_b}, 32'd0);
    check("rst_add_c0", {31'h0, add_c0}, 32'd0);

    //     a         b         cin   sub   result    cout  ovf   c0 (bit k = slice k)
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1111, 0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001, 0);
    // Backpressure in DONE with ignored operands offered meanwhile.
    run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1110, 3);
    run_op(16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 4'b0001, 0);

    // Reset during RUN at idx=2: the operation is dropped.
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'h0, in_ready}, 32'd1);
    check("abort_out_valid", {31'h0, out_valid}, 32'd0);
    check("abort_result", {16'h0, result}, 32'd0);
    check("abort_add_a", {28'h0, add_a}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_valid", {31'h0, out_valid}, 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ak_serial_add16.md
# ak_serial_add16

Nibble-serial 16-bit adder/subtractor controller that wraps the team's 4-bit ripple-carry adder stage. It accepts a pair of 16-bit operands on a valid/ready handshake and feeds the adder one nibble per cycle, LSB nibble first. It captures each 4-bit sum and carry-out and returns the full result, carry-out and signed overflow on a second valid/ready handshake. The adder is instantiated alongside this block, not inside it, so both blocks can be verified independently.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (16 by default)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op_a  in  W  operand A
- op_b  in  W  operand B
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  1 = compute op_a - op_b
- add_a  out  4  nibble of A driven to adder input A
- add_b  out  4  nibble of B (inverted when sub) driven to adder input B
- add_c0  out  1  carry driven to adder input C0
- add_sum  in  4  adder sum, combinational from add_a/add_b/add_c0
- add_c4  in  1  adder carry-out, combinational
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  W  sum or difference
- cout  out  1  final carry-out (for sub: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture op_a into a_reg.
  - capture op_b into b_reg, or ~op_b if sub=1.
  - carry_reg <= sub ? 1 : cin.
  - idx <= 0; go to RUN.
- RUN:
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_c0 = carry_reg.
  - Each edge: result[4*idx+3:4*idx] <= add_sum, carry_reg <= add_c4, idx <= idx+1.
  - On the edge where idx==NIBBLES-1: also cout <= add_c4, overflow <= (a_reg[W-1]==b_reg[W-1]) && (add_sum[3]!=a_reg[W-1]); go to DONE.
- DONE: out_valid=1. result, cout and overflow are held stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. There is no overlap between consecutive operations.
- Outside RUN, add_a, add_b and add_c0 are driven to 0.
- Arithmetic is modulo 2^W. Subtract is implemented as A + ~B + 1.
- idx width is clog2(NIBBLES), minimum 1 bit. idx never wraps past NIBBLES-1.

## Timing
- Reset: when rst_n=0 at a rising edge, the block enters IDLE with:
  - result=0, cout=0, overflow=0, carry_reg=0, idx=0, a_reg=0, b_reg=0.
  - out_valid=0, add_a/add_b/add_c0=0.
  - in_ready=1 from the first cycle after that edge.
- Reset while in RUN or DONE aborts the operation. The partial result is discarded and out_valid is never raised for it.
- Latency: an operation accepted at edge T raises out_valid in the cycle following edge T+NIBBLES (4 cycles for the default).
- result becomes valid with out_valid, not before. The low nibbles of result change during RUN, and the bench must ignore them while out_valid=0.
- out_valid stays high until a cycle with out_ready=1. IDLE is entered on that edge. The earliest next acceptance is the following edge, so minimum throughput is one operation per NIBBLES+2 cycles.
- in_valid is ignored when in_ready=0. Operands presented then are not captured.
- The adder path is combinational within one cycle: from add_a/add_b/add_c0 through the adder to add_sum/add_c4 into the register.

## Test plan
- Add 0x1234 + 0x4321, cin=0 -> result=0x5555, cout=0, overflow=0; out_valid 4 cycles after accept; add_a sequence 4,3,2,1.
- Add 0xFFFF + 0x0001, cin=0 -> result=0x0000, cout=1, overflow=0; add_c0 sequence 0,1,1,1.
- Add 0x7FFF + 0x0000, cin=1 -> result=0x8000, cout=0, overflow=1.
- Sub 0x0005 - 0x0007 -> result=0xFFFE, cout=0, overflow=0. Sub 0x8000 - 0x0001 -> result=0x7FFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result, cout and overflow stable, in_ready=0, and in_valid with new operands is ignored; with out_ready=1, IDLE follows, then the next operation is accepted.
- Reset mid-RUN: drop rst_n at idx=2 for one edge -> next cycle IDLE, in_ready=1, out_valid=0, result=0; the next operation 0x0001+0x0001 gives 0x0002.
